// File: rtl/dmem_access_seq.sv
`default_nettype none
// ============================================================================
// Module   : dmem_access_seq
// Purpose  : Load/store sequencer for a word-wide handshaked data memory;
//            sub-word stores use read-modify-write, sub-word loads extend.
// Revision : 1.0  initial release
// ============================================================================
module dmem_access_seq #(
  parameter int MEM_AW  = 10,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        mem_read,
  input  logic [1:0]        mem_write,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic [1:0]        err,
  output logic              m_req,
  output logic              m_we,
  output logic [MEM_AW-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata,
  input  logic              m_ack
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] LD_LW   = 3'b000;
  localparam logic [2:0] LD_LH   = 3'b001;
  localparam logic [2:0] LD_LHU  = 3'b010;
  localparam logic [2:0] LD_LB   = 3'b011;
  localparam logic [2:0] LD_LBU  = 3'b100;
  localparam logic [2:0] LD_NONE = 3'b101;

  localparam logic [1:0] ST_SW   = 2'b00;
  localparam logic [1:0] ST_SH   = 2'b01;
  localparam logic [1:0] ST_SB   = 2'b10;
  localparam logic [1:0] ST_NONE = 2'b11;

  localparam logic [1:0] E_OK    = 2'b00;
  localparam logic [1:0] E_ALIGN = 2'b01;
  localparam logic [1:0] E_TMO   = 2'b10;
  localparam logic [1:0] E_ILL   = 2'b11;

  localparam int             CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]  C_TMO = CW'(TIMEOUT);

  logic [1:0]    r_state;
  logic [1:0]    w_state_next;
  logic [2:0]    r_ld_size;
  logic [1:0]    r_st_size;
  logic [1:0]    r_lane;
  logic [15:0]   r_wdata_lo;
  logic [CW-1:0] r_cnt;

  logic          w_ld_none;
  logic          w_st_none;
  logic          w_illegal;
  logic          w_misal;
  logic [1:0]    w_dec_err;
  logic          w_timeout;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load_val;
  logic [31:0]   w_merged;
  logic          unused_addr_hi;

  assign unused_addr_hi = ^addr[31:MEM_AW+2];

  // Command decode, evaluated on the raw inputs while idle
  always_comb begin
    w_ld_none = (mem_read == LD_NONE);
    w_st_none = (mem_write == ST_NONE);
    w_illegal = (!w_ld_none && !w_st_none) || (mem_read[2:1] == 2'b11);
    w_misal   = 1'b0;
    if (!w_ld_none) begin
      case (mem_read)
        LD_LW:         w_misal = (addr[1:0] != 2'b00);
        LD_LH, LD_LHU: w_misal = addr[0];
        default:       w_misal = 1'b0;
      endcase
    end else begin
      case (mem_write)
        ST_SW:   w_misal = (addr[1:0] != 2'b00);
        ST_SH:   w_misal = addr[0];
        default: w_misal = 1'b0;
      endcase
    end
    if (w_illegal)    w_dec_err = E_ILL;
    else if (w_misal) w_dec_err = E_ALIGN;
    else              w_dec_err = E_OK;
  end

  assign w_timeout = (TIMEOUT != 0) && (r_cnt == C_TMO);

  always_comb begin
    w_byte = m_rdata[{r_lane, 3'b000} +: 8];
    w_half = r_lane[1] ? m_rdata[31:16] : m_rdata[15:0];
    case (r_ld_size)
      LD_LH:   w_load_val = {{16{w_half[15]}}, w_half};
      LD_LHU:  w_load_val = {16'h0000, w_half};
      LD_LB:   w_load_val = {{24{w_byte[7]}}, w_byte};
      LD_LBU:  w_load_val = {24'h000000, w_byte};
      default: w_load_val = m_rdata;
    endcase
  end

  always_comb begin
    w_merged = m_rdata;
    if (r_st_size == ST_SB) begin
      w_merged[{r_lane, 3'b000} +: 8] = r_wdata_lo[7:0];
    end else if (r_st_size == ST_SH) begin
      if (r_lane[1]) w_merged[31:16] = r_wdata_lo;
      else           w_merged[15:0]  = r_wdata_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_dec_err != E_OK)  w_state_next = S_DONE;
          else if (!w_ld_none)    w_state_next = S_RD;
          else if (!w_st_none)    w_state_next = (mem_write == ST_SW) ? S_WR : S_RD;
          else                    w_state_next = S_DONE;
        end
      end
      S_RD: begin
        if (m_ack)          w_state_next = (r_ld_size != LD_NONE) ? S_DONE : S_WR;
        else if (w_timeout) w_state_next = S_DONE;
      end
      S_WR: begin
        if (m_ack || w_timeout) w_state_next = S_DONE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
    done = (r_state == S_DONE);
  end

  // Memory-side outputs are registered from the next state so they are
  // glitch-free and held steady for the whole request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ld_size  <= LD_NONE;
      r_st_size  <= ST_NONE;
      r_lane     <= 2'b00;
      r_wdata_lo <= 16'h0000;
      r_cnt      <= '0;
      rdata      <= 32'h0;
      err        <= E_OK;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ld_size  <= mem_read;
            r_st_size  <= mem_write;
            r_lane     <= addr[1:0];
            r_wdata_lo <= wdata[15:0];
            err        <= w_dec_err;
            m_addr     <= addr[MEM_AW+1:2];
          end
        end
        S_RD: begin
          if (m_ack) begin
            if (r_ld_size != LD_NONE) rdata <= w_load_val;
          end else if (w_timeout) begin
            err <= E_TMO;
          end
        end
        S_WR: begin
          if (!m_ack && w_timeout) err <= E_TMO;
        end
        default: ;
      endcase

      m_req <= (w_state_next == S_RD) || (w_state_next == S_WR);
      m_we  <= (w_state_next == S_WR);

      if ((r_state == S_IDLE) && (w_state_next == S_WR))
        m_wdata <= wdata;
      else if ((r_state == S_RD) && (w_state_next == S_WR))
        m_wdata <= w_merged;

      if (w_state_next != r_state)
        r_cnt <= '0;
      else if (((r_state == S_RD) || (r_state == S_WR)) && !m_ack)
        r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_seq.sv
`default_nettype none
// Bench for dmem_access_seq: table of directed commands against a word
// memory responder with programmable ack delay, plus corner-case sequences.
module tb_dmem_access_seq;

  localparam int MEM_AW  = 10;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [2:0]        mem_read;
  logic [1:0]        mem_write;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic [31:0]       rdata;
  logic [1:0]        err;
  logic              m_req;
  logic              m_we;
  logic [MEM_AW-1:0] m_addr;
  logic [31:0]       m_wdata;
  logic [31:0]       m_rdata;
  logic              m_ack;

  dmem_access_seq #(.MEM_AW(MEM_AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .mem_read(mem_read),
    .mem_write(mem_write), .addr(addr), .wdata(wdata), .busy(busy),
    .done(done), .rdata(rdata), .err(err), .m_req(m_req), .m_we(m_we),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory responder
  logic [31:0]       mem [0:1023];
  int                ack_delay = 0;
  int                wait_cnt = 0;
  bit                acked_last = 0;
  int                req_cycles = 0;
  int                rd_count = 0;
  int                wr_count = 0;
  logic [MEM_AW-1:0] last_raddr = '0;
  logic [MEM_AW-1:0] last_waddr = '0;
  logic [31:0]       last_wdata = '0;
  bit                prev_req = 0;
  logic [42:0]       prev_bus = '0;

  initial begin
    m_ack   = 1'b0;
    m_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (m_req && prev_req && !m_ack)
        chk("req_stable", {21'h0, m_we, m_addr, m_wdata}, {21'h0, prev_bus});
      prev_req = m_req;
      prev_bus = {m_we, m_addr, m_wdata};
      m_ack = 1'b0;
      if (acked_last) begin
        wait_cnt   = 0;
        acked_last = 0;
      end
      if (m_req) begin
        req_cycles++;
        if (ack_delay >= 0 && wait_cnt == ack_delay) begin
          m_ack      = 1'b1;
          acked_last = 1;
          if (m_we) begin
            mem[m_addr] = m_wdata;
            last_waddr  = m_addr;
            last_wdata  = m_wdata;
            wr_count++;
          end else begin
            m_rdata    = mem[m_addr];
            last_raddr = m_addr;
            rd_count++;
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Issue one command; lat counts cycles from the accepting edge to done.
  task automatic run_cmd(input logic [2:0] mr, input logic [1:0] mw,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic busy1);
    @(negedge clk);
    mem_read = mr; mem_write = mw; addr = a; wdata = wd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    busy1 = busy;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  typedef struct {
    logic [2:0]  mr;
    logic [1:0]  mw;
    logic [31:0] a;
    logic [31:0] wd;
    int          dly;
    logic [31:0] memw;
    int          lat;
    logic [1:0]  e;
    logic [31:0] rd;
    int          nrd;
    int          nwr;
    logic [31:0] wword;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int lat;
    logic busy1;
    int rd0, wr0, rq0;

    vecs[0]  = '{3'b000, 2'b11, 32'h10, 32'h0,        0, 32'hDEADBEEF, 2, 2'b00, 32'hDEADBEEF, 1, 0, 32'h0};
    vecs[1]  = '{3'b011, 2'b11, 32'h23, 32'h0,        1, 32'h8070F001, 3, 2'b00, 32'hFFFFFF80, 1, 0, 32'h0};
    vecs[2]  = '{3'b100, 2'b11, 32'h23, 32'h0,        0, 32'h8070F001, 2, 2'b00, 32'h00000080, 1, 0, 32'h0};
    vecs[3]  = '{3'b001, 2'b11, 32'h22, 32'h0,        2, 32'h8070F001, 4, 2'b00, 32'hFFFF8070, 1, 0, 32'h0};
    vecs[4]  = '{3'b010, 2'b11, 32'h22, 32'h0,        0, 32'h8070F001, 2, 2'b00, 32'h00008070, 1, 0, 32'h0};
    vecs[5]  = '{3'b011, 2'b11, 32'h20, 32'h0,        0, 32'h8070F001, 2, 2'b00, 32'h00000001, 1, 0, 32'h0};
    vecs[6]  = '{3'b001, 2'b11, 32'h20, 32'h0,        0, 32'h8070F001, 2, 2'b00, 32'hFFFFF001, 1, 0, 32'h0};
    vecs[7]  = '{3'b101, 2'b10, 32'h31, 32'h000000AB, 2, 32'h11223344, 7, 2'b00, 32'hFFFFF001, 1, 1, 32'h1122AB44};
    vecs[8]  = '{3'b101, 2'b01, 32'h32, 32'h0000BEEF, 0, 32'h11223344, 3, 2'b00, 32'hFFFFF001, 1, 1, 32'hBEEF3344};
    vecs[9]  = '{3'b101, 2'b00, 32'h40, 32'hCAFEF00D, 1, 32'h0,        3, 2'b00, 32'hFFFFF001, 0, 1, 32'hCAFEF00D};
    vecs[10] = '{3'b000, 2'b11, 32'h13, 32'h0,        0, 32'h0,        1, 2'b01, 32'hFFFFF001, 0, 0, 32'h0};
    vecs[11] = '{3'b000, 2'b00, 32'h0,  32'h0,        0, 32'h0,        1, 2'b11, 32'hFFFFF001, 0, 0, 32'h0};
    vecs[12] = '{3'b110, 2'b11, 32'h4,  32'h0,        0, 32'h0,        1, 2'b11, 32'hFFFFF001, 0, 0, 32'h0};
    vecs[13] = '{3'b101, 2'b01, 32'h33, 32'h1234,     0, 32'h0,        1, 2'b01, 32'hFFFFF001, 0, 0, 32'h0};
    vecs[14] = '{3'b101, 2'b11, 32'h8,  32'h0,        0, 32'h0,        1, 2'b00, 32'hFFFFF001, 0, 0, 32'h0};
    vecs[15] = '{3'b101, 2'b10, 32'h72, 32'h12345677, 0, 32'hAABBCCDD, 3, 2'b00, 32'hFFFFF001, 1, 1, 32'hAA77CCDD};

    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    reset = 1'b1; start = 1'b0; mem_read = 3'b101; mem_write = 2'b11;
    addr = 32'h0; wdata = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_err", err, 2'b00);
    chk("rst_mreq", {m_req, m_we}, 2'b00);
    chk("rst_maddr", m_addr, 10'h0);
    chk("rst_mwdata", m_wdata, 32'h0);

    for (int i = 0; i < 16; i++) begin
      mem[vecs[i].a[11:2]] = vecs[i].memw;
      ack_delay = vecs[i].dly;
      rd0 = rd_count; wr0 = wr_count; rq0 = req_cycles;
      run_cmd(vecs[i].mr, vecs[i].mw, vecs[i].a, vecs[i].wd, lat, busy1);
      chk($sformatf("v%0d_busy", i), busy1, 1'b1);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_err", i), err, vecs[i].e);
      chk($sformatf("v%0d_rdata", i), rdata, vecs[i].rd);
      chk($sformatf("v%0d_nrd", i), rd_count - rd0, vecs[i].nrd);
      chk($sformatf("v%0d_nwr", i), wr_count - wr0, vecs[i].nwr);
      if (vecs[i].nrd + vecs[i].nwr == 0)
        chk($sformatf("v%0d_noreq", i), req_cycles - rq0, 0);
      if (vecs[i].nrd > 0)
        chk($sformatf("v%0d_raddr", i), last_raddr, vecs[i].a[11:2]);
      if (vecs[i].nwr > 0) begin
        chk($sformatf("v%0d_waddr", i), last_waddr, vecs[i].a[11:2]);
        chk($sformatf("v%0d_wword", i), last_wdata, vecs[i].wword);
      end
    end

    // start held high while busy with a different command
    mem[4] = 32'hDEADBEEF;
    ack_delay = 2;
    rd0 = rd_count; wr0 = wr_count;
    @(negedge clk);
    mem_read = 3'b000; mem_write = 2'b11; addr = 32'h10; start = 1'b1;
    @(negedge clk);
    mem_read = 3'b101; mem_write = 2'b00; wdata = 32'h55555555;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("busy_start_lat", lat, 4);
    chk("busy_start_rdata", rdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("busy_start_idle", busy, 1'b0);
    chk("busy_start_nwr", wr_count - wr0, 0);
    chk("busy_start_nrd", rd_count - rd0, 1);
    chk("busy_start_mem", mem[4], 32'hDEADBEEF);

    // SW never acked: watchdog
    ack_delay = -1;
    rq0 = req_cycles; wr0 = wr_count;
    run_cmd(3'b101, 2'b00, 32'h50, 32'h01234567, lat, busy1);
    chk("tmo_sw_lat", lat, TIMEOUT + 2);
    chk("tmo_sw_err", err, 2'b10);
    chk("tmo_sw_reqcyc", req_cycles - rq0, TIMEOUT + 1);
    repeat (5) @(negedge clk);
    chk("tmo_sw_noretry", req_cycles - rq0, TIMEOUT + 1);

    // SB whose read never completes must not write
    mem[24] = 32'h01020304;
    rq0 = req_cycles; wr0 = wr_count;
    run_cmd(3'b101, 2'b10, 32'h61, 32'hFF, lat, busy1);
    chk("tmo_sb_lat", lat, TIMEOUT + 2);
    chk("tmo_sb_err", err, 2'b10);
    chk("tmo_sb_reqcyc", req_cycles - rq0, TIMEOUT + 1);
    chk("tmo_sb_nwr", wr_count - wr0, 0);
    chk("tmo_sb_mem", mem[24], 32'h01020304);

    // reset during RD wait, then a normal LW
    @(negedge clk);
    mem_read = 3'b000; mem_write = 2'b11; addr = 32'h10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("mid_rst_req_before", m_req, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_req", m_req, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_rdata", rdata, 32'h0);
    chk("mid_rst_err", err, 2'b00);
    chk("mid_rst_maddr", {m_we, m_addr}, 11'h0);
    reset = 1'b0;
    ack_delay = 0;
    run_cmd(3'b000, 2'b11, 32'h10, 32'h0, lat, busy1);
    chk("post_rst_lat", lat, 2);
    chk("post_rst_rdata", rdata, 32'hDEADBEEF);
    chk("post_rst_err", err, 2'b00);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
